mdr_seq_ctrl: RTL and testbench
===============================

MDR_SEQ_CTRL -- requirements
Module: mdr_seq_ctrl

Interface
- REQ-001: Parameter W_DATA, default 16, operand width; SHALL be even and >= 4.
- REQ-002: Parameter W_DEPTH, default 2*W_DATA, result width; SHALL equal 2*W_DATA.
- REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: start  input  1  request to begin an operation; sampled only when ready=1.
- REQ-006: op  input  2  operation select: 00 multiply, 01 divide, 10 square root, 11 illegal.
- REQ-007: data_a  input  W_DATA  multiplicand, dividend or radicand (unsigned).
- REQ-008: data_b  input  W_DATA  multiplier or divisor (unsigned); ignored for square root.
- REQ-009: ready  output  1  high only in state IDLE.
- REQ-010: done  output  1  one-cycle pulse marking a valid result or error.
- REQ-011: error  output  1  high with done when the operation failed; low otherwise.
- REQ-012: result  output  W_DEPTH  registered result; held between done pulses.

Function
- REQ-013: The FSM SHALL have states IDLE, RUN, DONE and ERR, and no others.
- REQ-014: In IDLE with start=1, the edge (E0) SHALL capture op, data_a and data_b into internal registers; later input changes SHALL have no effect on the operation.
- REQ-015: At E0, op 00 or 10, or op 01 with data_b!=0, SHALL go to RUN with the iteration counter loaded to N; op 01 with data_b=0, or op 11, SHALL go to ERR.
- REQ-016: N SHALL be W_DATA for multiply and divide, and W_DATA/2 for square root.
- REQ-017: RUN SHALL perform one iteration per edge and decrement the counter; the edge performing the last iteration SHALL load result and go to DONE.
- REQ-018: done SHALL be high only in DONE or ERR, each lasting exactly one cycle; both states SHALL return to IDLE on the next edge.
- REQ-019: Latency SHALL be: done high in cycle N+1 for RUN operations and in cycle 1 for ERR, where cycle 1 is the cycle immediately after E0.
- REQ-020: Multiply SHALL use unsigned shift-add, giving result = data_a*data_b with the full W_DEPTH bits.
- REQ-021: Divide SHALL use restoring division, giving result = {remainder, quotient}, each W_DATA bits.
- REQ-022: Square root SHALL use restoring integer sqrt over 2 bits per iteration, giving result = {remainder, root}, each zero-extended to W_DATA bits.
- REQ-023: Divide-by-zero SHALL give error=1, with result = {data_a, all ones}.
- REQ-024: op 11 SHALL give error=1, with result = 0.
- REQ-025: start while ready=0 (RUN, DONE, ERR) SHALL be ignored and not queued.
- REQ-026: error SHALL be 0 in every cycle where done=0.
- REQ-027: result SHALL change only on an edge that enters DONE or ERR.
- REQ-028: Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following each DONE or ERR.

Reset
- REQ-029: rst=0 SHALL immediately force state IDLE, counter 0, done=0, error=0 and result=0, independent of clk.
- REQ-030: ready SHALL be 1 while rst=0.
- REQ-031: rst asserted mid-operation SHALL abort it with no done pulse.
- REQ-032: After rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
- REQ-033: Multiply: op=00, a=0xFFFF, b=0xFFFF -> done in cycle 17, error=0, result=0xFFFE0001.
- REQ-034: Divide: op=01, a=100, b=7 -> done in cycle 17, result=0x0002000E; then a=0x0005, b=0x0009 -> result=0x00050000.
- REQ-035: Square root: op=10, a=0xFFFF -> done in cycle 9, result=0x01FE00FF; then a=0x0000 -> result=0.
- REQ-036: Errors: op=01, a=0x1234, b=0 -> done=error=1 in cycle 1, result=0x1234FFFF; op=11 -> done=error=1 in cycle 1, result=0.
- REQ-037: Busy/abort: start pulsed in cycle 5 of a multiply -> ignored, single done in cycle 17 with the original result; rst=0 in cycle 8 of a divide -> no done, outputs at reset values, ready=1.
- REQ-038: Back-to-back: start held high with four different multiplies -> four done pulses 18 cycles apart, each result correct.

Source files
------------

// File: rtl/mdr_seq_ctrl.sv
// Iterative multiply / divide / square-root sequencer: one shift-add, restoring-divide
// or restoring-sqrt iteration per clock, with a single registered result port.
module mdr_seq_ctrl #(
    parameter int W_DATA  = 16,
    parameter int W_DEPTH = 2 * W_DATA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [W_DATA-1:0]  data_a,
    input  logic [W_DATA-1:0]  data_b,
    output logic               ready,
    output logic               done,
    output logic               error,
    output logic [W_DEPTH-1:0] result,
    output logic [1:0]         state_dbg
);

    // Handshake: start is sampled only on an edge where ready=1 (ready is high exactly in IDLE);
    // done is a one-cycle pulse, error is only meaningful with done, and result holds until the next pulse.

    localparam int W_CNT = $clog2(W_DATA + 1);
    localparam logic [W_CNT-1:0] N_FULL = W_CNT'(W_DATA);
    localparam logic [W_CNT-1:0] N_HALF = W_CNT'(W_DATA / 2);
    localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W_CNT-1:0]  cnt;
    logic [1:0]        op_q;
    logic [W_DATA-1:0] a_q, b_q;
    logic [W_DATA-1:0] acc_hi, acc_lo, root_q;

    logic [W_DATA-1:0]  hi_step, lo_step, root_step;
    logic [W_DEPTH-1:0] res_step;

    logic              accept, start_err, last_iter;
    logic [W_DATA:0]   mul_sum;
    logic [W_DATA:0]   div_x;
    logic [W_DATA-1:0] div_x_lo;
    logic              div_ge;
    logic [W_DATA+1:0] sq_rem, sq_trial;
    logic              sq_ge;

    assign accept    = (state == S_IDLE) && start;
    assign start_err = (op == OP_ILL) || ((op == OP_DIV) && (data_b == '0));
    assign last_iter = (state == S_RUN) && (cnt == CNT_ONE);

    // One iteration of the selected algorithm on the current accumulator.
    always_comb begin
        hi_step   = acc_hi;
        lo_step   = acc_lo;
        root_step = root_q;
        res_step  = '0;

        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);

        div_x    = {acc_hi, acc_lo[W_DATA-1]};
        div_x_lo = {acc_hi[W_DATA-2:0], acc_lo[W_DATA-1]};
        div_ge   = div_x >= {1'b0, b_q};

        sq_rem   = {acc_hi, acc_lo[W_DATA-1:W_DATA-2]};
        sq_trial = {root_q, 2'b01};
        sq_ge    = sq_rem >= sq_trial;

        case (op_q)
            OP_MUL: begin
                hi_step  = mul_sum[W_DATA:1];
                lo_step  = {mul_sum[0], acc_lo[W_DATA-1:1]};
                res_step = {hi_step, lo_step};
            end
            OP_DIV: begin
                // Remainder stays below the divisor, so the top shifted-out bit is redundant.
                hi_step  = div_ge ? (div_x_lo - b_q) : div_x_lo;
                lo_step  = {acc_lo[W_DATA-2:0], div_ge};
                res_step = {hi_step, lo_step};
            end
            OP_SQRT: begin
                hi_step   = sq_ge ? (sq_rem[W_DATA-1:0] - sq_trial[W_DATA-1:0])
                                  : sq_rem[W_DATA-1:0];
                lo_step   = {acc_lo[W_DATA-3:0], 2'b00};
                root_step = {root_q[W_DATA-2:0], sq_ge};
                res_step  = {hi_step, root_step};
            end
            default: begin
                res_step = '0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = start_err ? S_ERR : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            root_q <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= op;
            a_q    <= data_a;
            b_q    <= data_b;
            acc_hi <= '0;
            acc_lo <= (op == OP_MUL) ? data_b : data_a;
            root_q <= '0;
            if (start_err) begin
                cnt    <= '0;
                result <= (op == OP_DIV) ? {data_a, {W_DATA{1'b1}}} : '0;
            end else begin
                cnt <= (op == OP_SQRT) ? N_HALF : N_FULL;
            end
        end else if (state == S_RUN) begin
            acc_hi <= hi_step;
            acc_lo <= lo_step;
            root_q <= root_step;
            cnt    <= cnt - CNT_ONE;
            if (last_iter) begin
                result <= res_step;
            end
        end
    end

    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE) || (state == S_ERR);
    assign error     = (state == S_ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Directed bench for mdr_seq_ctrl: a vector table for single operations plus
// hand-written busy, abort and back-to-back sequences.
module tb_mdr_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        ready;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic        err;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[15];

    mdr_seq_ctrl #(.W_DATA(16), .W_DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .data_a    (data_a),
        .data_b    (data_b),
        .ready     (ready),
        .done      (done),
        .error     (error),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: called at a negedge with the DUT idle; the next rising edge is E0.
    // Inputs are scrambled after capture so later changes must not matter.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        start  = 1'b1;
        op     = o;
        data_a = a;
        data_b = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 2'(($urandom_range(0, 3)));
        data_a = 16'($urandom_range(0, 65535));
        data_b = 16'($urandom_range(0, 65535));
    endtask

    // Entered at the negedge of cycle 1; returns the cycle in which done is seen.
    // inj > 0 pulses start (with an illegal op) during that cycle.
    task automatic wait_done(input int inj, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (inj > 0 && c == inj) begin
                start = 1'b1;
                op    = 2'b11;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c;
                got = 1'b1;
                break;
            end
            chk("error_low_without_done", {63'd0, error}, 64'd0);
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within 40 cycles, required one");
        end
    endtask

    initial begin
        int          lat;
        bit          got;
        logic [31:0] held;
        int          k;
        int          last_done;
        logic [15:0] b2b_a[4];
        logic [15:0] b2b_b[4];

        vecs[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 17, 1'b0, 32'hFFFE0001};
        vecs[1]  = '{2'b00, 16'h1234, 16'h0010, 17, 1'b0, 32'h00012340};
        vecs[2]  = '{2'b00, 16'h0000, 16'hABCD, 17, 1'b0, 32'h00000000};
        vecs[3]  = '{2'b00, 16'hFFFF, 16'h0001, 17, 1'b0, 32'h0000FFFF};
        vecs[4]  = '{2'b01, 16'd100,  16'd7,    17, 1'b0, 32'h0002000E};
        vecs[5]  = '{2'b01, 16'h0005, 16'h0009, 17, 1'b0, 32'h00050000};
        vecs[6]  = '{2'b01, 16'hFFFF, 16'h0001, 17, 1'b0, 32'h0000FFFF};
        vecs[7]  = '{2'b01, 16'hFFFF, 16'hFFFF, 17, 1'b0, 32'h00000001};
        vecs[8]  = '{2'b01, 16'd1000, 16'd10,   17, 1'b0, 32'h00000064};
        vecs[9]  = '{2'b10, 16'hFFFF, 16'h5555,  9, 1'b0, 32'h01FE00FF};
        vecs[10] = '{2'b10, 16'h0000, 16'h1111,  9, 1'b0, 32'h00000000};
        vecs[11] = '{2'b10, 16'd100,  16'h0000,  9, 1'b0, 32'h0000000A};
        vecs[12] = '{2'b10, 16'd99,   16'h0000,  9, 1'b0, 32'h00120009};
        vecs[13] = '{2'b01, 16'h1234, 16'h0000,  1, 1'b1, 32'h1234FFFF};
        vecs[14] = '{2'b11, 16'hBEEF, 16'h0042,  1, 1'b1, 32'h00000000};

        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        data_a = '0;
        data_b = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_ready",  {63'd0, ready}, 64'd1);
        chk("reset_done",   {63'd0, done},  64'd0);
        chk("reset_error",  {63'd0, error}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_state",  {62'd0, state_dbg}, 64'd0);
        rst = 1'b1;

        // Vector table
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, lat, got);
            if (got) begin
                chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
                chk($sformatf("v%0d_error", i), {63'd0, error}, {63'd0, vecs[i].err});
                chk($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vecs[i].res});
                held = result;
                @(negedge clk);
                chk($sformatf("v%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
                chk($sformatf("v%0d_ready_after", i), {63'd0, ready}, 64'd1);
                chk($sformatf("v%0d_result_held", i), {32'd0, result}, {32'd0, held});
            end
        end

        // Start pulsed in cycle 5 of a multiply is ignored
        issue(2'b00, 16'h1234, 16'h5678);
        chk("busy_ready_low", {63'd0, ready}, 64'd0);
        wait_done(5, lat, got);
        if (got) begin
            chk("busy_latency", 64'(lat), 64'd17);
            chk("busy_error",   {63'd0, error}, 64'd0);
            chk("busy_result",  {32'd0, result}, 64'h06260060);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("busy_no_second_done", {63'd0, done}, 64'd0);
            chk("busy_idle_ready", {63'd0, ready}, 64'd1);
        end

        // Reset in cycle 8 of a divide aborts it
        issue(2'b01, 16'd100, 16'd7);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("abort_ready",  {63'd0, ready}, 64'd1);
        chk("abort_done",   {63'd0, done},  64'd0);
        chk("abort_error",  {63'd0, error}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_state",  {62'd0, state_dbg}, 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        rst = 1'b1;

        // First start after reset release is taken on the first rising edge
        issue(2'b01, 16'd100, 16'd7);
        wait_done(0, lat, got);
        if (got) begin
            chk("post_reset_latency", 64'(lat), 64'd17);
            chk("post_reset_result",  {32'd0, result}, 64'h0002000E);
        end
        @(negedge clk);

        // Back-to-back multiplies with start held high
        b2b_a = '{16'd3, 16'h00FF, 16'h8000, 16'hFFFF};
        b2b_b = '{16'd5, 16'h00FF, 16'h0002, 16'h0002};
        exp_q.push_back(32'h0000000F);
        exp_q.push_back(32'h0000FE01);
        exp_q.push_back(32'h00010000);
        exp_q.push_back(32'h0001FFFE);
        k         = 0;
        last_done = 0;
        start  = 1'b1;
        op     = 2'b00;
        data_a = b2b_a[0];
        data_b = b2b_b[0];
        for (int c = 1; c <= 120 && k < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk($sformatf("b2b%0d_spacing", k), 64'(c - last_done), (k == 0) ? 64'd17 : 64'd18);
                chk($sformatf("b2b%0d_error", k), {63'd0, error}, 64'd0);
                if (exp_q.size() > 0) begin
                    chk($sformatf("b2b%0d_result", k), {32'd0, result}, {32'd0, exp_q.pop_front()});
                end
                last_done = c;
                k++;
                if (k < 4) begin
                    data_a = b2b_a[k];
                    data_b = b2b_b[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 64'(k), 64'd4);
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        chk("b2b_idle_after", {63'd0, ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
